// File: rtl/adder_bist_sequencer.sv
// BIST sequencer for the broadcast-driven ripple-carry adder: applies the four pin patterns,
// waits SETTLE cycles each and records mismatches. Define ADDER_BIST_STOP_ON_FAIL_EN to end a pass at the first mismatch.
//
// state | meaning
// IDLE  | pins parked at 0, waiting for start
// HOLD  | pattern applied, settle down-counter running
// CHECK | response compared, fail_mask updated, next pattern launched
// DONE  | one-cycle done pulse, pins parked, pass published
module adder_bist_sequencer #(
    parameter int N      = 16,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] sum,
    input  logic         cout,
    output logic         pin_a,
    output logic         pin_b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [3:0]   fail_mask
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pin_a_nxt, pin_b_nxt, pass_nxt;
    logic [3:0]    fail_mask_nxt;
    logic          mismatch;
    logic [3:0]    mask_upd;
    logic          last_pattern;

    // Expected response follows from the pins: sum = {N{pin_b}}, cout = pin_a.
    assign mismatch = (sum != {N{pin_b}}) || (cout != pin_a);
    assign mask_upd = fail_mask | ({3'b000, mismatch} << idx);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign last_pattern = (idx == 2'd3) || mismatch;
`else
    assign last_pattern = (idx == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= '0;
            pin_a     <= 1'b0;
            pin_b     <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'b0000;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            pin_a     <= pin_a_nxt;
            pin_b     <= pin_b_nxt;
            pass      <= pass_nxt;
            fail_mask <= fail_mask_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        pin_a_nxt     = pin_a;
        pin_b_nxt     = pin_b;
        pass_nxt      = pass;
        fail_mask_nxt = fail_mask;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    fail_mask_nxt = 4'b0000;
                    pass_nxt      = 1'b0;
                    idx_nxt       = 2'd0;
                    pin_a_nxt     = 1'b0;
                    pin_b_nxt     = 1'b0;
                    cnt_nxt       = CNT_LOAD;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = CHECK;
                else           cnt_nxt   = cnt - CW'(1);
            end
            CHECK: begin
                busy          = 1'b1;
                fail_mask_nxt = mask_upd;
                if (last_pattern) begin
                    // pass is published on entry so it is already valid while done is high
                    pin_a_nxt = 1'b0;
                    pin_b_nxt = 1'b0;
                    pass_nxt  = (mask_upd == 4'b0000);
                    state_nxt = DONE;
                end else begin
                    idx_nxt                = idx + 2'd1;
                    {pin_a_nxt, pin_b_nxt} = idx + 2'd1;
                    cnt_nxt                = CNT_LOAD;
                    state_nxt              = HOLD;
                end
            end
            DONE: begin
                done      = 1'b1;
                pin_a_nxt = 1'b0;
                pin_b_nxt = 1'b0;
                pass_nxt  = (fail_mask == 4'b0000);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
